// File: rtl/video_fx_pkg.sv
// -----------------------------------------------------------------------------
// video_fx_pkg
// Shared definitions for the per-pixel video effect stage:
//   - mode encodings for the runtime effect selector
//   - fixed pipeline latency of the stage
//   - packed timing record (blank/hsync/vsync) carried alongside pixels
//   - helpers: saturating clamp to a channel depth, mode sanitising
// -----------------------------------------------------------------------------
package video_fx_pkg;

   localparam logic [2:0] MODE_BYPASS  = 3'd0;
   localparam logic [2:0] MODE_SHARPEN = 3'd1;
   localparam logic [2:0] MODE_BLUR    = 3'd2;
   localparam logic [2:0] MODE_INVERT  = 3'd3;
   localparam logic [2:0] MODE_BARS    = 3'd4;

   // Clocks from input pins to output pins, identical for every mode.
   localparam int unsigned FX_LATENCY = 32'd3;

   typedef struct packed {
      logic blank;
      logic hsync;
      logic vsync;
   } sync_t;

   // Timing value presented while the pipeline is held in reset.
   localparam sync_t SYNC_IDLE = '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};

   // Saturate a signed intermediate to the unsigned range [0, 2^depth-1].
   // Works on a 16-bit container so any supported depth fits.
   function automatic logic [15:0] sat_clamp(input logic signed [15:0] value,
                                             input int                 depth);
      logic [15:0] max_u;
      logic [15:0] res;
      max_u = 16'((32'd1 << depth) - 32'd1);
      if (value < 16'sd0) begin
         res = 16'd0;
      end else if (value > $signed(max_u)) begin
         res = max_u;
      end else begin
         res = $unsigned(value);
      end
      return res;
   endfunction

   // Unused encodings fall back to bypass.
   function automatic logic [2:0] sanitize_mode(input logic [2:0] m);
      logic [2:0] res;
      if (m > MODE_BARS) begin
         res = MODE_BYPASS;
      end else begin
         res = m;
      end
      return res;
   endfunction

endpackage

// File: rtl/video_fx_channel.sv
// -----------------------------------------------------------------------------
// video_fx_channel
// Combinational 3-tap effect for one colour channel.
//   mode          : effect in force (bypass, sharpen, blur, invert; bars and
//                   unknown codes pass the centre through, the top overrides)
//   left/right    : neighbour samples, with their own blank flags
//   centre        : pixel being processed
//   result        : processed value, always within [0, 2^C_depth-1]
// A blanked neighbour is replaced by the centre so line edges do not pull
// in blanking-interval data.
// -----------------------------------------------------------------------------
module video_fx_channel
   import video_fx_pkg::*;
#(
   parameter int C_depth       = 8,
   parameter int C_sharp_shift = 1
) (
   input  logic [2:0]         mode,
   input  logic [C_depth-1:0] left,
   input  logic               left_blank,
   input  logic [C_depth-1:0] centre,
   input  logic [C_depth-1:0] right,
   input  logic               right_blank,
   output logic [C_depth-1:0] result
);

   localparam int SW = C_depth + 3;

   logic [C_depth-1:0]   left_eff_s;
   logic [C_depth-1:0]   right_eff_s;
   logic signed [SW-1:0] c_ext_s;
   logic signed [SW-1:0] l_ext_s;
   logic signed [SW-1:0] r_ext_s;
   logic signed [SW-1:0] hp_s;
   logic signed [SW-1:0] sharp_sum_s;
   logic signed [15:0]   sharp_wide_s;
   logic [15:0]          sharp_clamp_s;
   logic [15-C_depth:0]  sharp_unused_s;
   logic [C_depth-1:0]   sharp_s;
   logic [C_depth+1:0]   blur_sum_s;
   logic [1:0]           blur_unused_s;
   logic [C_depth-1:0]   blur_s;
   logic [C_depth-1:0]   invert_s;

   assign left_eff_s  = left_blank  ? centre : left;
   assign right_eff_s = right_blank ? centre : right;

   // Sharpen: c + ((2c - l - r) >>> shift); the high-pass term is signed so
   // the arithmetic shift keeps negative edges negative.
   assign c_ext_s      = $signed({3'b000, centre});
   assign l_ext_s      = $signed({3'b000, left_eff_s});
   assign r_ext_s      = $signed({3'b000, right_eff_s});
   assign hp_s         = (c_ext_s <<< 1) - l_ext_s - r_ext_s;
   assign sharp_sum_s  = c_ext_s + (hp_s >>> C_sharp_shift);
   assign sharp_wide_s = {{(16-SW){sharp_sum_s[SW-1]}}, sharp_sum_s};
   assign sharp_clamp_s = sat_clamp(sharp_wide_s, C_depth);
   assign {sharp_unused_s, sharp_s} = sharp_clamp_s;

   // Blur: (l + 2c + r) >> 2, truncating; two extra bits hold the full sum.
   assign blur_sum_s = {2'b00, left_eff_s} + {1'b0, centre, 1'b0} + {2'b00, right_eff_s};
   assign {blur_s, blur_unused_s} = blur_sum_s;

   assign invert_s = {C_depth{1'b1}} - centre;

   // Effect select for this channel.
   always_comb begin
      result = centre;
      case (mode)
         MODE_SHARPEN: result = sharp_s;
         MODE_BLUR:    result = blur_s;
         MODE_INVERT:  result = invert_s;
         default:      result = centre;
      endcase
   end

endmodule

// File: rtl/video_fx_pipe.sv
// -----------------------------------------------------------------------------
// video_fx_pipe
// Per-pixel video effect stage in the pixel clock domain.
//   clk, reset                 : pixel clock, asynchronous active-high reset
//   mode                       : requested effect, latched at vsync leading edge
//   in_blank/in_hsync/in_vsync : input timing
//   in_red/in_green/in_blue    : input pixel, C_depth bits per channel
//   out_blank/hsync/vsync      : timing delayed to match the pixel path
//   out_red/out_green/out_blue : processed pixel
//   out_mode                   : effect currently in force
// Pipeline: input taps t0 (right) -> t1 (centre) -> t2 (left); the output
// register is fed from the centre tap. Timing travels t0 -> t1 -> out, so it
// sees the same three registers as the pixels.
// -----------------------------------------------------------------------------
module video_fx_pipe
   import video_fx_pkg::*;
#(
   parameter int   C_depth       = 8,
   parameter int   C_sharp_shift = 1,
   parameter int   C_bar_shift   = 7,
   parameter logic C_vsync_pol   = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         mode,
   input  logic               in_blank,
   input  logic               in_hsync,
   input  logic               in_vsync,
   input  logic [C_depth-1:0] in_red,
   input  logic [C_depth-1:0] in_green,
   input  logic [C_depth-1:0] in_blue,
   output logic               out_blank,
   output logic               out_hsync,
   output logic               out_vsync,
   output logic [C_depth-1:0] out_red,
   output logic [C_depth-1:0] out_green,
   output logic [C_depth-1:0] out_blue,
   output logic [2:0]         out_mode
);

   localparam int XW = C_bar_shift + 3;

   // Channel order inside a pixel word: [2] red, [1] green, [0] blue.
   typedef logic [2:0][C_depth-1:0] pix3_t;

   pix3_t         t0_pix_r;
   pix3_t         t1_pix_r;
   pix3_t         t2_pix_r;
   sync_t         t0_sync_r;
   sync_t         t1_sync_r;
   logic          t2_blank_r;
   logic [2:0]    active_mode_r;
   logic [XW-1:0] x_r;
   pix3_t         out_pix_r;
   sync_t         out_sync_r;

   pix3_t         fx_pix_s;
   pix3_t         bar_pix_s;
   pix3_t         next_pix_s;
   logic [2:0]    bar_s;
   logic          vsync_edge_s;

   // t0 still holds the previous in_vsync, so it doubles as the edge detector.
   assign vsync_edge_s = (in_vsync == C_vsync_pol) && (t0_sync_r.vsync != C_vsync_pol);

   // Tap shift register; taps come out of reset as blanked black pixels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t0_pix_r   <= '0;
         t1_pix_r   <= '0;
         t2_pix_r   <= '0;
         t0_sync_r  <= SYNC_IDLE;
         t1_sync_r  <= SYNC_IDLE;
         t2_blank_r <= 1'b1;
      end else begin
         t0_pix_r   <= {in_red, in_green, in_blue};
         t0_sync_r  <= '{blank: in_blank, hsync: in_hsync, vsync: in_vsync};
         t1_pix_r   <= t0_pix_r;
         t1_sync_r  <= t0_sync_r;
         t2_pix_r   <= t1_pix_r;
         t2_blank_r <= t1_sync_r.blank;
      end
   end

   // Effect latch: mode changes only at the vsync leading edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_mode_r <= MODE_BYPASS;
      end else if (vsync_edge_s) begin
         active_mode_r <= sanitize_mode(mode);
      end else begin
         active_mode_r <= active_mode_r;
      end
   end

   // Active-pixel position along the line, restarted by any blanked centre.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_r <= '0;
      end else if (t1_sync_r.blank) begin
         x_r <= '0;
      end else begin
         x_r <= x_r + XW'(1);
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      video_fx_channel #(
         .C_depth       (C_depth),
         .C_sharp_shift (C_sharp_shift)
      ) u_chan (
         .mode        (active_mode_r),
         .left        (t2_pix_r[ch]),
         .left_blank  (t2_blank_r),
         .centre      (t1_pix_r[ch]),
         .right       (t0_pix_r[ch]),
         .right_blank (t0_sync_r.blank),
         .result      (fx_pix_s[ch])
      );
   end

   // Eight bars across the line; each bar bit drives one whole channel.
   assign bar_s     = x_r[XW-1 -: 3];
   assign bar_pix_s = {{C_depth{bar_s[2]}}, {C_depth{bar_s[1]}}, {C_depth{bar_s[0]}}};

   // Final pixel select: blanking forces black ahead of any effect.
   always_comb begin
      next_pix_s = '0;
      if (t1_sync_r.blank) begin
         next_pix_s = '0;
      end else if (active_mode_r == MODE_BARS) begin
         next_pix_s = bar_pix_s;
      end else begin
         next_pix_s = fx_pix_s;
      end
   end

   // Output register for pixel and timing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_pix_r  <= '0;
         out_sync_r <= SYNC_IDLE;
      end else begin
         out_pix_r  <= next_pix_s;
         out_sync_r <= t1_sync_r;
      end
   end

   assign out_red   = out_pix_r[2];
   assign out_green = out_pix_r[1];
   assign out_blue  = out_pix_r[0];
   assign out_blank = out_sync_r.blank;
   assign out_hsync = out_sync_r.hsync;
   assign out_vsync = out_sync_r.vsync;
   assign out_mode  = active_mode_r;

endmodule

// File: doc/video_fx_pipe.md
Name: video_fx_pipe

Overview:
Parametrised per-pixel video effect stage for the VGA-to-HDMI chain. It sits between the pattern generator and the dvid encoder, in the clk_pixel domain, and supersedes the fixed single-effect filter. It provides C_depth-bit RGB, several runtime-selectable modes, and frame-synchronous mode switching. Sync and blank are delay-matched to pixel data.

Parameters:
C_depth, 8, bits per colour channel (4..10)
C_sharp_shift, 1, right-shift applied to the sharpen high-pass term (0..3)
C_bar_shift, 7, log2 of colour-bar width in active pixels
C_vsync_pol, 1, active level of in_vsync, used for mode latching only

Ports:
clk  in  1  pixel clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high
mode  in  3  requested mode: 0 bypass, 1 sharpen, 2 blur, 3 invert, 4 colour bars, 5-7 bypass
in_blank, in_hsync, in_vsync  in  1 each  input timing
in_red, in_green, in_blue  in  C_depth each  input pixel
out_blank, out_hsync, out_vsync  out  1 each  timing, delayed 3 clk
out_red, out_green, out_blue  out  C_depth each  processed pixel
out_mode  out  3  mode currently in effect

Behaviour:
- Reset is asynchronous and active-high.
  - Under reset: all out_* pixel values are 0, out_blank=1, out_hsync=0, out_vsync=0, out_mode=0.
  - Under reset: tap registers and x counter are 0.
  - Asserting reset mid-frame takes effect immediately.
  - After release, outputs reflect input from 3 clocks earlier.
- Pipeline: input register t0 -> centre register t1 (with neighbours t0 = right, t2 = left) -> registered output.
  - Fixed latency is 3 clk for all modes, including bypass.
  - Sync and blank go through an identical 3-stage delay, so there are no bubbles.
  - Each tap also carries its own blank flag.
- Mode latching:
  - active_mode loads `mode` on the clock where in_vsync transitions to the C_vsync_pol level (edge detect on a registered copy).
  - No other change occurs mid-frame.
  - Values 5-7 are stored as 0.
  - out_mode = active_mode.
- Neighbour replication: if the left tap is blanked, left := centre; if the right tap is blanked, right := centre. This is evaluated per channel per pixel.
- Arithmetic, per channel, with c/l/r as C_depth unsigned values:
  - sharpen: hp = 2c - l - r, signed, width C_depth+3. result = c + (hp >>> C_sharp_shift), using an arithmetic shift. Clamp to [0, 2^C_depth-1].
  - blur: (l + 2c + r) >> 2, truncating, width C_depth+2 internally.
  - invert: (2^C_depth-1) - c.
  - bypass: c.
- Colour bars:
  - x counter increments on each non-blank centre pixel and clears on a blanked centre. It is C_bar_shift+3 bits and wraps.
  - bar = x[C_bar_shift+2:C_bar_shift].
  - R = all ones if bar[2] else 0; G follows bar[1]; B follows bar[0].
  - Input pixels are ignored in this mode.
- A blanked centre pixel always produces out RGB = 0, regardless of mode.
- Simultaneous events: a vsync edge on the same clock as a mode change loads the new mode. The pixel being output on that clock still uses the old mode; the new mode applies from the next clock.

Decomposition:
- Shared package holds:
  - mode encoding constants (MODE_BYPASS=0, MODE_SHARPEN=1, MODE_BLUR=2, MODE_INVERT=3, MODE_BARS=4)
  - the fixed latency constant 3
  - a function for saturating clamp to C_depth.
- One sub-module, video_fx_channel: the per-channel 3-tap compute (sharpen/blur/invert/clamp), instantiated three times.
- Taps, sync delay, mode latch and bar counter stay in the top of this block.

Test Plan:
- Reset and latency:
  - Assert reset mid-line -> outputs 0, out_blank=1, out_mode=0 within the same cycle.
  - Release reset, drive a bypass ramp -> out pixel equals in pixel 3 clk later; hsync/vsync/blank aligned.
- Sharpen (C_depth=8, shift=1):
  - Triplet l=100, c=200, r=100 -> 255 (clamped from 300).
  - Triplet 50, 60, 70 -> 60.
  - Triplet 200, 0, 200 -> 0 (clamped from -200).
- Blur and invert:
  - Blur on 10, 20, 31 -> 20.
  - Invert on c=100 -> 155.
  - Blanked pixel in any mode -> 0.
- Edge replication:
  - Single active pixel c=80 between blanks, sharpen and blur -> 80.
  - First active pixel 100 followed by 50, blur -> (100+200+50)>>2 = 87.
- Mode latching:
  - Change mode 0->1 mid-frame -> out_mode stays 0 until the next vsync leading edge, then becomes 1.
  - Write mode 6 -> out_mode = 0 after vsync.
- Colour bars:
  - C_bar_shift=2, 32 active pixels -> bars 0..7 each 4 pixels wide.
  - Bar 5 gives R=255, G=0, B=255.
  - Counter restarts at 0 after hblank.
